// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the fp32 add/sub ALU and its handshake wrapper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          EXP_W     = 8;
  localparam int          MAN_W     = 23;
  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Leading-zero count of the 27-bit working mantissa (mantissa + guard/round/sticky).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_li_alu.sv
// alu: combinational fp32 add/sub (round-to-nearest-even, subnormals flushed to
// signed zero) with the result registered once.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  // Subtraction is addition with the sign of B inverted.
  assign sa     = a[31];
  assign sb     = b[31] ^ (op == OP_SUB);
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign fa     = a[22:0];
  assign fb     = b[22:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == EXP_MAX) && (fb == '0);
  assign a_nan  = (ea == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == EXP_MAX) && (fb != '0);

  logic               big_s, sml_s;
  logic [7:0]         big_e, sml_e, diff;
  logic [23:0]        big_m, sml_m;
  logic [50:0]        shifted;
  logic [26:0]        aligned;
  logic [27:0]        sum;
  logic [26:0]        norm;
  logic [4:0]         lz;
  logic signed [9:0]  exp_n;
  logic               rnd_up;
  logic [24:0]        rnd_m;
  logic [23:0]        mant;
  logic [31:0]        res_c;

  // Special-case selection, then align / add / normalise / round for two normal operands.
  always_comb begin
    big_s   = sa;
    sml_s   = sb;
    big_e   = ea;
    sml_e   = eb;
    big_m   = {1'b1, fa};
    sml_m   = {1'b1, fb};
    diff    = '0;
    shifted = '0;
    aligned = '0;
    sum     = '0;
    norm    = '0;
    lz      = '0;
    exp_n   = '0;
    rnd_up  = 1'b0;
    rnd_m   = '0;
    mant    = '0;
    res_c   = '0;

    if ({ea, fa} < {eb, fb}) begin
      big_s = sb;
      sml_s = sa;
      big_e = eb;
      sml_e = ea;
      big_m = {1'b1, fb};
      sml_m = {1'b1, fa};
    end

    if (a_nan || b_nan) begin
      res_c = CANON_NAN;
    end else if (a_inf && b_inf) begin
      res_c = (sa != sb) ? CANON_NAN : {sa, EXP_MAX, 23'd0};
    end else if (a_inf) begin
      res_c = {sa, EXP_MAX, 23'd0};
    end else if (b_inf) begin
      res_c = {sb, EXP_MAX, 23'd0};
    end else if (a_zero && b_zero) begin
      // Only (-0)+(-0) keeps the negative sign.
      res_c = {sa & sb, 31'd0};
    end else if (a_zero) begin
      res_c = {sb, eb, fb};
    end else if (b_zero) begin
      res_c = {sa, ea, fa};
    end else begin
      diff = big_e - sml_e;
      // Smaller operand lands in [26:3] mantissa, [2] guard, [1] round, [0] sticky.
      if (diff >= 8'd27) begin
        aligned = 27'd1;
      end else begin
        shifted = {sml_m, 27'd0} >> diff;
        aligned = {shifted[50:25], |shifted[24:0]};
      end

      if (big_s != sml_s) sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};
      else                sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};

      if (sum == '0) begin
        res_c = 32'd0;
      end else begin
        if (sum[27]) begin
          norm  = {sum[27:2], sum[1] | sum[0]};
          exp_n = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
          lz    = lzc27(sum[26:0]);
          norm  = sum[26:0] << lz;
          exp_n = $signed({2'b00, big_e}) - $signed({5'd0, lz});
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd_m  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (rnd_m[24]) begin
          mant  = rnd_m[24:1];
          exp_n = exp_n + 10'sd1;
        end else begin
          mant  = rnd_m[23:0];
        end

        if (exp_n >= 10'sd255)     res_c = {big_s, EXP_MAX, 23'd0};
        else if (exp_n <= 10'sd0)  res_c = {big_s, 31'd0};
        else                       res_c = {big_s, exp_n[7:0], mant[22:0]};
      end
    end
  end

  // Single register stage on the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result <= '0;
    else        result <= res_c;
  end

endmodule

// File: rtl/alu_li.sv
// alu_li: valid/ready wrapper around the fp32 add/sub ALU.
// Operands are captured on acceptance, the ALU register stage forms BUSY, and the
// result is presented in DONE until downstream takes it.
// Optional macro ALU_LI_SVA_EN compiles in protocol assertions.
//
//   state | meaning
//   IDLE  | ready_out high, waiting for valid_in
//   BUSY  | captured operands passing through the ALU register stage
//   DONE  | valid_out high, result_out held until ready_in
module alu_li
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             op_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] result_out,
  output logic             valid_out,
  input  logic             ready_in
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             accept;

  assign accept = (state_q == IDLE) && valid_in;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_d = BUSY;
      end
      BUSY: state_d = DONE;
      DONE: begin
        valid_out = 1'b1;
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture; the copies stay fixed through BUSY and DONE, which keeps the
  // ALU register (and so result_out) stable while waiting on ready_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 1'b0;
    end else if (accept) begin
      a_q  <= a_in;
      b_q  <= b_in;
      op_q <= op_in;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .clk    (clk),
    .reset  (reset),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result_out)
  );

`ifdef ALU_LI_SVA_EN
  // Result must not move while the consumer is stalling.
  a_result_stable: assert property (@(posedge clk) disable iff (!reset)
    (valid_out && !ready_in) |=> $stable(result_out));

  // The cycle after acceptance is always BUSY.
  a_no_early_valid: assert property (@(posedge clk) disable iff (!reset)
    (valid_in && ready_out) |=> !valid_out);

  // Handshake outputs are always driven once out of reset.
  a_no_x_handshake: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({ready_out, valid_out}));
`else
  // Protocol checks not compiled into this build.
`endif

endmodule

// File: tb/tb_alu_li.sv
// tb_alu_li: directed and random checks of alu_li against a real-arithmetic fp32 model.
module tb_alu_li;

  logic        clk;
  logic        reset;
  logic [31:0] a_in, b_in;
  logic        op_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] result_out;
  logic        valid_out;
  logic        ready_in;

  int n_checks = 0;
  int n_err    = 0;

  alu_li #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .result_out (result_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // fp32 -> double, subnormal inputs read as signed zero.
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] de;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    de = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], de, f[22:0], 29'd0});
  endfunction

  // double -> fp32 with round-to-nearest-even; overflow to Inf, tiny results to signed zero.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] keep;
    logic [24:0] k25;
    logic [28:0] rem;
    int          e;
    bit          up;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 1023 + 127;
    keep = {1'b1, d[51:29]};
    rem  = d[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    k25  = {1'b0, keep} + {24'd0, up};
    if (k25[24]) begin
      e++;
      keep = k25[24:1];
    end else begin
      keep = k25[23:0];
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b_raw, input logic op);
    logic [31:0] b;
    bit a_nan, b_nan, a_inf, b_inf;
    b     = op ? (b_raw ^ 32'h8000_0000) : b_raw;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:0] == 31'h7F80_0000);
    b_inf = (b[30:0] == 31'h7F80_0000);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  // One full transaction from IDLE; hold = DONE stall cycles with ready_in low.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input int hold, input bit keep_valid);
    logic [31:0] exp_r;
    exp_r = ref_add(a, b, op);
    chk({tag, "_ready_idle"}, {31'd0, ready_out}, 32'd1);
    a_in     = a;
    b_in     = b;
    op_in    = op;
    valid_in = 1'b1;
    ready_in = (hold == 0);
    step();
    a_in  = $urandom;
    b_in  = $urandom;
    op_in = 1'($urandom);
    if (!keep_valid) valid_in = 1'b0;
    chk({tag, "_busy_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_busy_ready"}, {31'd0, ready_out}, 32'd0);
    step();
    chk({tag, "_done_valid"}, {31'd0, valid_out}, 32'd1);
    chk({tag, "_result"}, result_out, exp_r);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, {31'd0, valid_out}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, ready_out}, 32'd0);
      chk({tag, "_hold_result"}, result_out, exp_r);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    chk({tag, "_release_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_release_ready"}, {31'd0, ready_out}, 32'd1);
  endtask

  function automatic logic [31:0] special_pick(input int k);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FA0_0001;
      5: return 32'h0040_0000;
      6: return 32'h7F7F_FFFF;
      default: return 32'h0080_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rop;
    logic [7:0]  ex;
    int          mode;

    reset    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    op_in    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, valid_out}, 32'd0);

    run_txn("add_1_2", 32'h3F80_0000, 32'h4000_0000, 1'b0, 0, 1'b0);
    run_txn("sub_1_2", 32'h3F80_0000, 32'h4000_0000, 1'b1, 0, 1'b0);
    run_txn("sub_1_1", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 0, 1'b0);
    run_txn("inf_minf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 0, 1'b0);
    run_txn("max_max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 1'b0);
    run_txn("nz_nz", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_txn("nz_sub_pz", 32'h8000_0000, 32'h0000_0000, 1'b1, 0, 1'b0);
    run_txn("subn_in", 32'h0040_0000, 32'h3F80_0000, 1'b0, 0, 1'b0);
    run_txn("subn_out", 32'h0080_0001, 32'h0080_0000, 1'b1, 0, 1'b0);
    run_txn("inf_fin", 32'hFF80_0000, 32'h4000_0000, 1'b1, 0, 1'b0);
    run_txn("rne_tie", 32'h4B80_0000, 32'h3F80_0000, 1'b0, 0, 1'b0);
    run_txn("stall5", 32'h4049_0FDB, 32'hC02D_F854, 1'b0, 5, 1'b0);
    run_txn("held_valid", 32'h4120_0000, 32'h3DCC_CCCD, 1'b1, 2, 1'b1);
    step();
    chk("single_take_ready", {31'd0, ready_out}, 32'd1);
    chk("single_take_valid", {31'd0, valid_out}, 32'd0);

    // Reset while BUSY.
    a_in = 32'h3F80_0000; b_in = 32'h4000_0000; op_in = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
    step();
    valid_in = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_busy_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_busy_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_busy_result", result_out, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy_no_stale", {31'd0, valid_out}, 32'd0);
      chk("rst_busy_idle", {31'd0, ready_out}, 32'd1);
    end

    // Reset while DONE.
    a_in = 32'h4000_0000; b_in = 32'h4000_0000; op_in = 1'b0; valid_in = 1'b1; ready_in = 1'b0;
    step();
    valid_in = 1'b0;
    step();
    chk("pre_rst_done_valid", {31'd0, valid_out}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_done_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_done_result", result_out, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_done_no_stale", {31'd0, valid_out}, 32'd0);
    end

    // Random operands, downstream always ready.
    for (int n = 0; n < 10000; n++) begin
      mode = int'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      rop  = 1'($urandom);
      case (mode)
        1: begin
          ex = ra[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
          rb = {rb[31], ex, rb[22:0]};
        end
        2: rb = {rb[31], ra[30:5], rb[4:0]};
        3: begin
          if ($urandom_range(0, 1) == 0) ra = special_pick(int'($urandom_range(0, 7)));
          else                           rb = special_pick(int'($urandom_range(0, 7)));
        end
        default: ;
      endcase
      run_txn("rand", ra, rb, rop, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_li.md
ALU_LI -- requirements
Module: alu_li

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a_in  input  WIDTH  operand A, fp32 bit pattern.
REQ-005 b_in  input  WIDTH  operand B, fp32 bit pattern.
REQ-006 op_in  input  1  operation: 0 = A+B, 1 = A-B.
REQ-007 valid_in  input  1  upstream offers a request.
REQ-008 ready_out  output  1  block can accept a request.
REQ-009 result_out  output  WIDTH  fp32 result.
REQ-010 valid_out  output  1  result_out is valid.
REQ-011 ready_in  input  1  downstream accepts result.

Function
REQ-012 States IDLE, BUSY, DONE; ready_out = (state==IDLE); valid_out = (state==DONE).
REQ-013 IDLE: valid_in=1 at rising edge captures a_in, b_in, op_in; next state BUSY.
REQ-014 BUSY lasts exactly one cycle (sub-module register stage); next state DONE; valid_out rises 2 cycles after the accepting edge.
REQ-015 DONE: result_out held stable until valid_out && ready_in at an edge; then IDLE; ready_out high the following cycle.
REQ-016 valid_in while not IDLE is ignored; a request held high across the accepting edge is taken once only.
REQ-017 Inputs need not stay stable after acceptance; captured copies are used.
REQ-018 Subtraction = addition with B sign inverted.
REQ-019 Rounding round-to-nearest-even; exact zero sum yields +0 except (-0)+(-0) = -0.
REQ-020 Subnormal inputs treated as zero of same sign; subnormal results flushed to signed zero.
REQ-021 Overflow yields signed infinity; Inf+finite = Inf; Inf-Inf or any NaN input yields 0x7FC00000.
REQ-022 result_out bit-identical to sub-module ALU result for the same operands and op.

Reset
REQ-023 reset low: state IDLE, ready_out=1 after reset, valid_out=0, result_out=0, captured operands 0, immediately and asynchronously.
REQ-024 Reset mid-BUSY or mid-DONE discards the transaction; no valid_out after release until a new accept.

Configuration
REQ-025 Macro ALU_LI_SVA_EN: defined -> protocol assertions compiled in (result_out stable while valid_out && !ready_in; valid_out never high in cycle after acceptance; no X on ready_out/valid_out out of reset); undefined -> no assertions, identical RTL behaviour.

Structure
REQ-026 Package alu_pkg: state enum (IDLE, BUSY, DONE), fp32 field widths (exponent 8, mantissa 23, bias 127), canonical NaN constant 0x7FC00000, op encoding constants.
REQ-027 One sub-module ALU (ports clk, reset, op, a, b, result): combinational fp32 add/sub with result registered one cycle; alu_li instantiates it and adds handshake FSM and operand capture.

Verification
REQ-028 A=0x3F800000, B=0x40000000, op=0 -> result_out 0x40400000, valid_out 2 cycles after accept.
REQ-029 A=0x3F800000, B=0x40000000, op=1 -> 0xBF800000; A=B=0x3F800000, op=1 -> 0x00000000.
REQ-030 A=0x7F800000, B=0xFF800000, op=0 -> 0x7FC00000; A=B=0x7F7FFFFF, op=0 -> 0x7F800000.
REQ-031 Hold ready_in=0 for 5 cycles in DONE -> valid_out stays 1, result_out constant, ready_out 0; raise ready_in -> IDLE next cycle.
REQ-032 Assert reset during BUSY -> valid_out 0, ready_out 1 after release, no stale result emitted.
REQ-033 10000 random (A, B, op) with ready_in=1 -> alu_li result bit-identical to standalone ALU, zero mismatches.
